// File: rtl/parking_gate_ctrl.sv
// Entrance gate controller for a multi-slot car park.
// Password check, lockout, entry timeout and occupancy tracking.
module parking_gate_ctrl #(
    parameter int PW_W = 2,
    parameter logic [PW_W-1:0] PASSWORD_1 = 2'b01,
    parameter logic [PW_W-1:0] PASSWORD_2 = 2'b10,
    parameter int CAPACITY = 8,
    parameter int MAX_TRIES = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int TIMEOUT = 64,
    localparam int CNT_W = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entrance_sensor_input,
    input  logic             exit_sensor_input,
    input  logic [PW_W-1:0]  password_1,
    input  logic [PW_W-1:0]  password_2,
    input  logic             password_valid,
    output logic             GREEN_LED,
    output logic             RED_LED,
    output logic             gate_open,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             lockout
);

    localparam int TMAX = (TIMEOUT > LOCK_CYCLES) ? TIMEOUT : LOCK_CYCLES;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam int TR_W = $clog2(MAX_TRIES + 1);
    localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LK_LAST = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [TR_W-1:0] TR_MAX = TR_W'(MAX_TRIES);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PASSWORD,
        WRONG_PASS,
        RIGHT_PASS,
        LOCKED
    } state_t;

    state_t           state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [TR_W-1:0]  tries, tries_n;
    logic [CNT_W-1:0] occ_n;
    logic             full_wait, full_wait_n;
    logic             exit_prev;
    logic             exit_event;
    logic             car_in;
    logic             pw_ok;

    assign full = (occupancy == CAP);
    assign exit_event = exit_sensor_input & ~exit_prev;
    assign pw_ok = (password_1 == PASSWORD_1) && (password_2 == PASSWORD_2);

    // State, counters and exit-edge history register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            tries     <= '0;
            occupancy <= '0;
            full_wait <= 1'b0;
            exit_prev <= 1'b1;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            tries     <= tries_n;
            occupancy <= occ_n;
            full_wait <= full_wait_n;
            exit_prev <= exit_sensor_input;
        end
    end

    // Next-state, timer and tries logic.
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        tries_n     = tries;
        full_wait_n = 1'b0;
        car_in      = 1'b0;
        unique case (state)
            IDLE: begin
                full_wait_n = entrance_sensor_input & full;
                if (entrance_sensor_input && !full) begin
                    state_n = WAIT_PASSWORD;
                    timer_n = '0;
                end
            end
            WAIT_PASSWORD, WRONG_PASS: begin
                if (password_valid) begin
                    timer_n = '0;
                    if (pw_ok) begin
                        state_n = RIGHT_PASS;
                        tries_n = '0;
                    end else begin
                        tries_n = tries + 1'b1;
                        if (tries_n == TR_MAX) state_n = LOCKED;
                        else state_n = WRONG_PASS;
                    end
                end else if (!entrance_sensor_input || timer == TO_LAST) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            RIGHT_PASS: begin
                if (!entrance_sensor_input) begin
                    state_n = IDLE;
                    car_in  = 1'b1;
                end
            end
            LOCKED: begin
                if (timer == LK_LAST) begin
                    state_n = IDLE;
                    tries_n = '0;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Occupancy: entries add, exit edges subtract, a coincident pair cancels.
    always_comb begin
        occ_n = occupancy;
        if (car_in && !exit_event) occ_n = occupancy + 1'b1;
        else if (!car_in && exit_event && occupancy != '0) occ_n = occupancy - 1'b1;
    end

    // Moore output decode from registered state.
    always_comb begin
        GREEN_LED = 1'b0;
        RED_LED   = 1'b0;
        gate_open = 1'b0;
        lockout   = 1'b0;
        unique case (state)
            IDLE:          RED_LED = full_wait;
            WAIT_PASSWORD: RED_LED = 1'b1;
            WRONG_PASS:    RED_LED = 1'b1;
            RIGHT_PASS: begin
                GREEN_LED = 1'b1;
                gate_open = 1'b1;
            end
            LOCKED: begin
                RED_LED = 1'b1;
                lockout = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
